// File: rtl/led_row_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : led_row_scanner_if
// Description : Frame handshake between the cell array (master) and the LED
//               row scanner (slave). A frame transfers on a clock edge where
//               frame_valid & frame_ready are both high.
// Signals     : frame_valid  master -> slave  frame_data holds a frame
//               frame_data   master -> slave  N_ROWS*N_COLS bits; row r is
//                                             bits [r*N_COLS +: N_COLS]
//               frame_ready  slave -> master  scanner accepts frame_data
// Revision    : 1.0  initial release
// ============================================================================
interface led_row_scanner_if #(
   parameter int N_ROWS = 4,
   parameter int N_COLS = 8
) ();

   logic                       frame_valid;
   logic [N_ROWS*N_COLS-1:0]   frame_data;
   logic                       frame_ready;

   modport master (
      output frame_valid,
      output frame_data,
      input  frame_ready
   );

   modport slave (
      input  frame_valid,
      input  frame_data,
      output frame_ready
   );

endinterface : led_row_scanner_if
`default_nettype wire

// File: rtl/led_row_scanner.sv
`default_nettype none
// ============================================================================
// Module      : led_row_scanner
// Description : Time-multiplexed row scanner for the LED matrix. Cycles a row
//               index/enable into a downstream row decoder and presents the
//               column pattern of the lit row. A whole-frame snapshot is
//               taken through a valid/ready handshake, only at a frame
//               boundary, so a frame is never shown half-updated.
// Macro       : LED_ROW_SCANNER_BLANK_EN - when defined, each row is preceded
//               by BLANK_CYCLES dark cycles; when undefined the blanking
//               phase is compiled out and rows follow back to back.
// Ports       : clk          system clock, rising edge
//               rst_n        asynchronous active-low reset
//               ena          scan enable
//               frame_if     slave side of the frame handshake
//               row_sel      row index to the decoder input
//               row_ena      decoder enable (row lit)
//               col_data     column pattern for the lit row
//               frame_start  pulse on the first lit cycle of row 0
// Revision    : 1.0  initial release
// ============================================================================
module led_row_scanner #(
   parameter  int N_ROWS       = 4,
   parameter  int N_COLS       = 8,
   parameter  int DRIVE_CYCLES = 1000,
   parameter  int BLANK_CYCLES = 16,
   localparam int ROW_W        = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   input  wire logic               ena,
   led_row_scanner_if.slave        frame_if,
   output logic [ROW_W-1:0]        row_sel,
   output logic                    row_ena,
   output logic [N_COLS-1:0]       col_data,
   output logic                    frame_start
);

   localparam int FB_W    = N_ROWS * N_COLS;
   localparam int CNT_MAX = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
`ifdef LED_ROW_SCANNER_BLANK_EN
      BLANK = 2'd1,
`endif
      DRIVE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [ROW_W-1:0]   row_q,   row_d;
   logic [FB_W-1:0]    fb_q;

   logic               drive_last;
   logic               row_last;
   logic [ROW_W-1:0]   row_next;
   logic               ready;

   assign drive_last = (cnt_q == CNT_W'(DRIVE_CYCLES - 1));
   assign row_last   = (row_q == ROW_W'(N_ROWS - 1));
   assign row_next   = row_last ? '0 : row_q + ROW_W'(1);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      row_ena     = 1'b0;
      col_data    = '0;
      frame_start = 1'b0;
      ready       = 1'b0;
      row_sel     = row_q;

      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (ena) begin
`ifdef LED_ROW_SCANNER_BLANK_EN
               state_d = BLANK;
`else
               state_d = DRIVE;
`endif
               cnt_d = '0;
               row_d = '0;
            end
         end

`ifdef LED_ROW_SCANNER_BLANK_EN
         BLANK: begin
            if (!ena) begin
               state_d = IDLE;
               cnt_d   = '0;
               row_d   = '0;
            end else if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
               state_d = DRIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif

         DRIVE: begin
            row_ena     = 1'b1;
            col_data    = fb_q[row_q*N_COLS +: N_COLS];
            frame_start = (row_q == '0) && (cnt_q == '0);
            // Last lit cycle of the last row is the only frame boundary.
            ready       = row_last && drive_last;
            if (!ena) begin
               state_d = IDLE;
               cnt_d   = '0;
               row_d   = '0;
            end else if (drive_last) begin
`ifdef LED_ROW_SCANNER_BLANK_EN
               state_d = BLANK;
`else
               state_d = DRIVE;
`endif
               cnt_d = '0;
               row_d = row_next;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            row_d   = '0;
         end
      endcase
   end

   assign frame_if.frame_ready = ready;

   // ------------------------------------------------------------------------
   // Frame buffer: a load at the wrap edge is already visible to row 0.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb_q <= '0;
      end else if (frame_if.frame_valid && ready) begin
         fb_q <= frame_if.frame_data;
      end
   end

endmodule : led_row_scanner
`default_nettype wire

// File: tb/tb_led_row_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_row_scanner
// Description : Directed self-checking bench for led_row_scanner with
//               N_ROWS=4, N_COLS=4, DRIVE_CYCLES=3, BLANK_CYCLES=2. Works with
//               LED_ROW_SCANNER_BLANK_EN defined or undefined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_led_row_scanner;

   localparam int N_ROWS = 4;
   localparam int N_COLS = 4;
   localparam int DRV    = 3;
   localparam int BLK    = 2;
`ifdef LED_ROW_SCANNER_BLANK_EN
   localparam int BLANK_EFF = BLK;
`else
   localparam int BLANK_EFF = 0;
`endif
   localparam int RP = BLANK_EFF + DRV;   // row period
   localparam int FP = N_ROWS * RP;       // frame period

   logic         clk;
   logic         rst_n;
   logic         ena;
   logic [1:0]   row_sel;
   logic         row_ena;
   logic [3:0]   col_data;
   logic         frame_start;

   int n_checks = 0;
   int n_fail   = 0;

   led_row_scanner_if #(.N_ROWS(N_ROWS), .N_COLS(N_COLS)) frame_if ();

   led_row_scanner #(
      .N_ROWS       (N_ROWS),
      .N_COLS       (N_COLS),
      .DRIVE_CYCLES (DRV),
      .BLANK_CYCLES (BLK)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .frame_if    (frame_if.slave),
      .row_sel     (row_sel),
      .row_ena     (row_ena),
      .col_data    (col_data),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and compare all outputs against the expected scan
   // position pos (cycles since the enabling edge) showing frame data.
   task automatic scan_cycle(input int pos, input logic [15:0] data);
      int         ph;
      int         row;
      logic       lit;
      logic [3:0] col;
      @(posedge clk);
      @(negedge clk);
      ph  = pos % RP;
      row = (pos / RP) % N_ROWS;
      lit = (ph >= BLANK_EFF);
      col = lit ? data[row*N_COLS +: N_COLS] : 4'h0;
      check($sformatf("row_ena@%0d", pos),     32'(row_ena),               32'(lit));
      check($sformatf("row_sel@%0d", pos),     32'(row_sel),               32'(row));
      check($sformatf("col_data@%0d", pos),    32'(col_data),              32'(col));
      check($sformatf("frame_start@%0d", pos), 32'(frame_start),           32'((pos % FP) == BLANK_EFF));
      check($sformatf("frame_ready@%0d", pos), 32'(frame_if.frame_ready),  32'((pos % FP) == FP - 1));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_row_ena"},     32'(row_ena),              32'h0);
      check({tag, "_row_sel"},     32'(row_sel),              32'h0);
      check({tag, "_col_data"},    32'(col_data),             32'h0);
      check({tag, "_frame_start"}, 32'(frame_start),          32'h0);
      check({tag, "_frame_ready"}, 32'(frame_if.frame_ready), 32'h1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int last_pos;
      rst_n                = 1'b0;
      ena                  = 1'b0;
      frame_if.frame_valid = 1'b0;
      frame_if.frame_data  = 16'h0000;

      #12;
      check_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Load a frame while idle.
      frame_if.frame_valid = 1'b1;
      frame_if.frame_data  = 16'hA5C3;
      @(posedge clk);
      @(negedge clk);
      frame_if.frame_valid = 1'b0;
      frame_if.frame_data  = 16'h0000;
      check_idle("idle_after_load");

      // Three frames; a new frame is offered mid-frame 1 and must only
      // land at the end of frame 1. Enable drops during row 2 of frame 3.
      ena      = 1'b1;
      last_pos = 3*FP + 2*RP + BLANK_EFF + 1;
      for (int pos = 0; pos <= last_pos; pos++) begin
         scan_cycle(pos, (pos < 2*FP) ? 16'hA5C3 : 16'hFFFF);
         if (pos == FP) begin
            frame_if.frame_valid = 1'b1;
            frame_if.frame_data  = 16'hFFFF;
         end
         if (pos == 2*FP) begin
            frame_if.frame_valid = 1'b0;
            frame_if.frame_data  = 16'h0000;
         end
         if (pos == last_pos) ena = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check_idle("ena_drop");

      // Restart, then reset asynchronously in the middle of row 1.
      ena = 1'b1;
      for (int pos = 0; pos <= RP + BLANK_EFF; pos++) begin
         scan_cycle(pos, 16'hFFFF);
      end
      #2;
      rst_n = 1'b0;
      ena   = 1'b0;
      #1;
      check_idle("async_reset");

      @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b1;
      for (int pos = 0; pos < FP; pos++) begin
         scan_cycle(pos, 16'h0000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_led_row_scanner
`default_nettype wire

// File: doc/led_row_scanner.md
# led_row_scanner

Time-multiplexed row scanner for the Game of Life LED matrix. It cycles a row index and row enable into the 2-to-4 row decoder directly downstream, and presents the matching column pattern for each row. It latches a whole-frame snapshot from the cell array upstream through a valid/ready handshake. New frames are accepted only at a frame boundary, so a frame is never displayed half-updated.

## Interface
Parameters:
- N_ROWS, 4, rows scanned; ROW_W = $clog2(N_ROWS); the default gives ROW_W = 2 to match the decoder input.
- N_COLS, 8, columns per row.
- DRIVE_CYCLES, 1000, clock cycles each row is lit; must be ≥ 1.
- BLANK_CYCLES, 16, dead cycles before each row is lit; must be ≥ 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  scan enable.
- frame_valid  input  1  upstream has a frame on frame_data.
- frame_data  input  N_ROWS*N_COLS  row r occupies bits [r*N_COLS +: N_COLS].
- frame_ready  output  1  the scanner accepts frame_data this cycle.
- row_sel  output  ROW_W  row index; drives the decoder `in`.
- row_ena  output  1  drives the decoder `ena`.
- col_data  output  N_COLS  column pattern for the lit row.
- frame_start  output  1  one-cycle pulse on the first lit cycle of row 0.

## Operation
- FSM states: IDLE, BLANK, DRIVE.
- Internal state: frame buffer fb (N_ROWS*N_COLS bits) and phase counter cnt.
- Reset: state=IDLE, fb=0, cnt=0. Outputs row_sel=0, row_ena=0, col_data=0, frame_start=0, frame_ready=1.
- IDLE:
  - Outputs held at reset values, except fb keeps its contents.
  - ena=1 → BLANK with row_sel=0, cnt=0.
- BLANK:
  - row_ena=0, col_data=0.
  - After BLANK_CYCLES cycles → DRIVE, cnt=0.
- DRIVE:
  - row_ena=1, col_data=fb[row_sel*N_COLS +: N_COLS].
  - After DRIVE_CYCLES cycles → BLANK with row_sel+1; N_ROWS-1 wraps to 0.
  - row_sel changes only on this DRIVE→BLANK edge, so the decoder input is stable whenever row_ena=1.
- ena=0 in any non-IDLE state → IDLE on the next edge; the current row is abandoned and row_sel returns to 0.
- Handshake:
  - frame_ready is 1 in IDLE and in the final DRIVE cycle of row N_ROWS-1; it is 0 otherwise.
  - fb loads frame_data on an edge where frame_valid & frame_ready.
  - A loaded frame is first displayed in the next row-0 DRIVE phase.
  - frame_valid without frame_ready has no effect; upstream holds its data until accepted.
- All outputs are driven from registered state. frame_ready and frame_start are decoded from state, cnt and row_sel.

## Timing
- Row period = BLANK_CYCLES + DRIVE_CYCLES; frame period = N_ROWS × row period.
- ena rise → row 0 lit after BLANK_CYCLES+1 edges. The first edge enters BLANK; frame_start is asserted with row_ena on that cycle.
- frame_start repeats exactly once per frame period while ena stays high.
- ena fall → row_ena=0 and row_sel=0 one edge later.
- rst_n low mid-scan → all outputs at reset values immediately (asynchronous); fb cleared.
- When frame_valid & frame_ready coincide with the DRIVE→BLANK wrap, the load and the wrap happen on the same edge; row 0 then uses the new fb.
- IDLE acceptance: a frame loaded while in IDLE is shown from the first lit row after ena rises.

## Configuration
- LED_ROW_SCANNER_BLANK_EN defined: the BLANK state is present as described.
- Undefined:
  - BLANK is compiled out and BLANK_CYCLES is ignored.
  - IDLE→DRIVE directly, and DRIVE→DRIVE with row_sel increment; row_ena stays 1 across row changes.
  - Row period = DRIVE_CYCLES.
  - frame_ready rules and the first-lit-cycle frame_start rule are unchanged.

## Test plan
Bench parameters: N_ROWS=4, N_COLS=4, DRIVE_CYCLES=3, BLANK_CYCLES=2, macro defined unless stated.
- Reset then ena=1 → row_ena=0 for 2 cycles, then 1 for 3 cycles with row_sel=0. Sequence repeats with row_sel=1,2,3,0; frame_start pulses every 20 cycles.
- In IDLE, frame_valid=1 with frame_data=16'hA5C3, then ena=1 → col_data 4'h3, 4'hC, 4'h5, 4'hA during rows 0–3. col_data=0 in every BLANK cycle.
- Mid-frame, frame_valid=1 with data=16'hFFFF → frame_ready stays 0 until the last DRIVE cycle of row 3. The load happens there; the next row-0 col_data is 4'hF, and prior rows still show the old data.
- ena dropped during row 2 DRIVE → next cycle row_ena=0, row_sel=0, state IDLE, frame_ready=1.
- rst_n pulsed low mid-row between clock edges → outputs go to reset values before the next edge; the fb read-back after restart is 0.
- Macro undefined → row_ena is constantly 1 after start; row_sel advances every 3 cycles; frame_start pulses every 12 cycles.
